serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor with borrow-in and borrow-out. Computes diff = a - b - bin, one bit per clock, LSB first.
- It is the inverse-operation counterpart of the team's parallel adder datapath. It trades latency for a single 1-bit full-subtractor cell.
- Sits beside the adder in the arithmetic unit. It is driven by a start/done handshake from the sequencing controller.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  borrow-in; captured on accepted start
- ready  output  1  high when a start will be accepted
- busy  output  1  high while bits are being processed
- diff  output  WIDTH  result; stable from done until next accepted start
- bout  output  1  final borrow-out; same stability as diff
- done  output  1  one-cycle pulse: diff/bout valid
- ovf  output  1  signed overflow (only with optional feature)

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE, diff=0, bout=0, done=0, busy=0, ready=1, ovf=0, internal shift registers and bit counter=0.
- FSM states: IDLE, SHIFT, DONE. All outputs are registered or decoded directly from state.
  - ready = (state != SHIFT).
  - busy = (state == SHIFT).
  - done = (state == DONE).
- IDLE: on start=1 at edge E0, capture a, b and borrow<=bin, clear counter, go to SHIFT. Otherwise stay.
- SHIFT: at each edge, take a0/b0 (the current LSBs of the operand shift registers) and the borrow flop br.
  - Bit result: d = a0 ^ b0 ^ br.
  - Next borrow: br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the result register from the MSB side. Shift both operand registers right. Increment the counter.
  - On the edge processing bit WIDTH-1 (edge E_WIDTH): load diff from the completed result and bout=br_next, then go to DONE.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH clocks after the start-sampling edge. Throughput is one operation per WIDTH+1 cycles.
- DONE: lasts exactly one cycle, then returns to IDLE. A start in the DONE cycle is accepted: go directly to SHIFT, back-to-back. done still pulses only that one cycle.
- start while busy=1: ignored. Captured operands are unaffected and no error is flagged.
- a, b, bin changes after capture: no effect on the operation in flight.
- diff/bout hold their last values through IDLE and SHIFT. They update only at edge E_WIDTH of the next operation.
- Reset asserted mid-operation: immediately returns everything to reset values. No done is produced for the aborted operation.
- Arithmetic is modulo 2^WIDTH; bout=1 means a < b + bin (unsigned).

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: port ovf exists.
  - At edge E_WIDTH, ovf <= br ^ br_next, i.e. borrow into MSB XOR borrow out of MSB, giving signed two's-complement overflow.
  - ovf holds with the same stability as diff and resets to 0.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic: WIDTH=4, a=9, b=3, bin=0, start 1 cycle -> busy for 4 cycles, done pulse 4 cycles after start edge; diff=6, bout=0.
- Underflow: a=3, b=9, bin=0 -> diff=4'hA, bout=1. Then a=0, b=0, bin=1 -> diff=4'hF, bout=1.
- Ignored start: start pulses with a=1, b=1 during SHIFT of a 9-3 op -> result still 6/0. Exactly one done pulse; ready=0 throughout SHIFT.
- Back-to-back: start asserted in the DONE cycle of 9-3 with a=15, b=15, bin=0 -> second done 4 cycles later; diff=0, bout=0. diff stays 6 until then.
- Reset mid-op: rst_n low at 2nd SHIFT cycle -> diff=0, bout=0, done=0, ready=1 immediately; no done pulse afterwards.
- Overflow (SERIAL_SUB_OVF_EN): a=4'h8, b=1 -> diff=4'h7, ovf=1. Then a=5, b=2 -> diff=3, ovf=0.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    // Sequencing controller side
    modport master (
        output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  ready, busy, diff, bout, done
    );

    // Subtractor side
    modport slave (
        input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output ready, busy, diff, bout, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB
// first, through a single full-subtractor cell. Optional signed-overflow
// output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current operand LSBs
    logic a0, b0, d_bit, br_next;
    assign a0      = a_sh_q[0];
    assign b0      = b_sh_q[0];
    assign d_bit   = a0 ^ b0 ^ br_q;
    assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

    // Next-state, datapath shifting and result capture
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            // DONE also accepts a start so operations can run back-to-back
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    br_d    = bus.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into MSB vs borrow out of MSB
                    ovf_d   = br_q ^ br_next;
`endif
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, async active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.ready = (state_q != SHIFT);
    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic/timing reference model checked
// every cycle, directed cases with literal results, then random traffic.
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted operation finishes WIDTH edges later
    bit           m_act = 0;
    int           m_edge = 0;
    int           ecnt = 0;
    bit           m_done = 0;
    logic [W-1:0] m_pd = '0, m_diff = '0;
    bit           m_pb = 0, m_bout = 0;
    bit           m_po = 0, m_ovf = 0;

    function automatic bit sovf(input logic [W-1:0] x, input logic [W-1:0] y, input bit c);
        int sx, sy, r;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        r  = sx - sy - int'(c);
        return (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_act = 0; m_done = 0; m_diff = '0; m_bout = 0; m_ovf = 0; ecnt = 0; m_edge = 0;
        end else begin
            bit rdy;
            logic [W:0] t;
            rdy = !(m_act && (ecnt - m_edge) < W);
            ecnt++;
            m_done = m_act && (ecnt - m_edge == W);
            if (m_done) begin
                m_diff = m_pd; m_bout = m_pb; m_ovf = m_po; m_act = 0;
            end
            if (rdy && bus.start) begin
                t = (W+1)'(bus.a) - (W+1)'(bus.b) - (W+1)'(bus.bin);
                m_pd = t[W-1:0]; m_pb = t[W]; m_po = sovf(bus.a, bus.b, bus.bin);
                m_act = 1; m_edge = ecnt;
            end
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (rst_n && run_cmp) begin
            bit ebusy;
            ebusy = m_act && (ecnt - m_edge) < W;
            chk("busy", bus.busy, ebusy);
            chk("ready", bus.ready, !ebusy);
            chk("done", bus.done, m_done);
            chk("diff", bus.diff, m_diff);
            chk("bout", bus.bout, m_bout);
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", bus.ovf, m_ovf);
`endif
        end
    end

    // Issue one op, wait for done with a bound, check latency and literal result
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit bi,
                          input logic [W-1:0] ed, input bit eb, input bit noise);
        int n;
        @(negedge clk);
        bus.start = 1; bus.a = a; bus.b = b; bus.bin = bi;
        wait_done(ed, eb, noise);
    endtask

    task automatic wait_done(input logic [W-1:0] ed, input bit eb, input bit noise);
        int n = 0;
        @(negedge clk);
        bus.start = 0;
        while (!bus.done && n < 3*W) begin
            if (noise) begin
                bus.start = 1; bus.a = 1; bus.b = 1; bus.bin = 0;
            end
            @(negedge clk);
            bus.start = 0;
            n++;
        end
        chk("latency", n, W);
        chk("lit_diff", bus.diff, ed);
        chk("lit_bout", bus.bout, eb);
    endtask

    initial begin
        int dcount;
        bus.start = 0; bus.a = '0; bus.b = '0; bus.bin = 0;
        #12;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_bout", bus.bout, 0);
        rst_n = 1;
        run_cmp = 1;

        run_op(4'd9, 4'd3, 0, 4'd6, 0, 0);
        run_op(4'd3, 4'd9, 0, 4'hA, 1, 0);
        run_op(4'd0, 4'd0, 1, 4'hF, 1, 0);
        // start pulses during SHIFT must be ignored
        run_op(4'd9, 4'd3, 0, 4'd6, 0, 1);
        // back-to-back: start in the DONE cycle
        run_op(4'd9, 4'd3, 0, 4'd6, 0, 0);
        bus.start = 1; bus.a = 4'd15; bus.b = 4'd15; bus.bin = 0;
        wait_done(4'd0, 0, 0);
`ifdef SERIAL_SUB_OVF_EN
        run_op(4'h8, 4'd1, 0, 4'h7, 0, 0);
        chk("lit_ovf1", bus.ovf, 1);
        run_op(4'd5, 4'd2, 0, 4'd3, 0, 0);
        chk("lit_ovf0", bus.ovf, 0);
`endif
        // leave a nonzero result so the reset clear is visible
        run_op(4'd9, 4'd3, 0, 4'd6, 0, 0);

        // reset in the second SHIFT cycle
        @(negedge clk);
        bus.start = 1; bus.a = 4'd7; bus.b = 4'd2; bus.bin = 0;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_ready", bus.ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_diff", bus.diff, 0);
        chk("mid_rst_bout", bus.bout, 0);
        @(negedge clk);
        rst_n = 1;
        dcount = 0;
        repeat (3*W) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        chk("no_done_after_rst", dcount, 0);

        // random traffic, including starts while busy and in DONE
        repeat (1500) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.bin = 1'($urandom);
        end
        @(negedge clk);
        bus.start = 0;
        repeat (2*W) @(negedge clk);
        run_cmp = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
